// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Wide-operand adder built around one 4-bit carry-lookahead slice. Operands of
// W = 4*NIBBLES bits are processed one nibble per clock, least significant
// nibble first. The slice carry-out is registered and fed into the next
// nibble. The finished sum is presented on a valid/ready result port.
//
// Optional feature macro: NSA_SUB_EN
//   defined   : sub=1 at accept computes a - b (b inverted, carry-in forced 1)
//   undefined : sub is ignored, the block only adds
//   The port list is the same in both builds.
//
// Parameters:
//   NIBBLES      operand width in nibbles (2..16), W = 4*NIBBLES
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, overrides everything
//   start_valid  request carries valid operands
//   start_ready  block can accept a request (IDLE only)
//   a, b         W-bit operands, sampled on accept
//   cin          carry into nibble 0, sampled on accept
//   sub          subtract request, sampled on accept (NSA_SUB_EN only)
//   busy         high while nibbles are being processed (RUN)
//   res_valid    result available (DONE)
//   res_ready    consumer takes the result
//   sum          W-bit result word
//   cout         carry out of the top nibble
//   overflow     signed two's-complement overflow
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid, once raised by the producer, is expected to stay high with
// stable payload until the transfer. start_ready, busy and res_valid are
// decoded straight from the state register, so no input reaches them
// combinationally.
// -----------------------------------------------------------------------------
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 overflow
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
    localparam logic [W-1:0]  NIB_MASK = {{(W-4){1'b0}}, 4'hF};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    // Operand B and carry-in as they are to be latched on accept.
    logic [W-1:0]    b_eff;
    logic            cin_eff;

`ifdef NSA_SUB_EN
    // a - b = a + ~b + 1; an incoming cin is overridden by the forced 1.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign cin_eff    = cin;
`endif

    // -------------------------------------------------------------------------
    // Nibble selection: shift the current nibble down to bit 0 instead of
    // using an indexed part-select, which keeps index widths independent of W.
    // -------------------------------------------------------------------------
    logic [W-1:0]    shamt;
    logic [W-1:0]    a_sh, b_sh;
    logic [3:0]      a_nib, b_nib;

    assign shamt = W'({idx_q, 2'b00});
    assign a_sh  = a_q >> shamt;
    assign b_sh  = b_q >> shamt;
    assign a_nib = a_sh[3:0];
    assign b_nib = b_sh[3:0];

    // -------------------------------------------------------------------------
    // 4-bit carry-lookahead slice. c[3] is the carry into the nibble's top bit;
    // on the last nibble that is the carry into bit W-1 used for overflow.
    // -------------------------------------------------------------------------
    logic [3:0]      g, p;
    logic [4:0]      c;
    logic [3:0]      s;

    assign g = a_nib & b_nib;
    assign p = a_nib ^ b_nib;

    assign c[0] = carry_q;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign s    = p ^ c[3:0];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                // start_ready is 1 throughout IDLE, so start_valid alone
                // decides the accept here. cout/overflow keep the previous
                // result until the new one is written.
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin_eff;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                sum_d   = (sum_q & ~(NIB_MASK << shamt)) | (W'(s) << shamt);
                carry_d = c[4];
                if (idx_q == LAST_IDX) begin
                    cout_d  = c[4];
                    ovf_d   = c[4] ^ c[3];
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_DONE: begin
                // New requests wait for IDLE, so an accept can happen no
                // earlier than the cycle after the result handoff.
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q == S_RUN);
    assign res_valid   = (state_q == S_DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Directed testbench for nibble_serial_adder with NIBBLES=4. Inputs are driven
// on the falling edge and outputs are sampled on the falling edge, half a
// cycle away from the active rising edge. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int checks;
    int errors;

    nibble_serial_adder #(
        .NIBBLES(NIBBLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .sub        (sub),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .sum        (sum),
        .cout       (cout),
        .overflow   (overflow)
    );

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then return to the falling edge for drive/sample.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full operation with continuous res_ready: checks busy for exactly
    // NIBBLES cycles, the result, one-cycle res_valid and retention in IDLE.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, input logic tsub,
                          input logic [W-1:0] esum, input logic ecout, input logic eovf);
        chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        a           = ta;
        b           = tb;
        cin         = tcin;
        sub         = tsub;
        start_valid = 1'b1;
        res_ready   = 1'b1;
        tick();
        start_valid = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        sub         = 1'b0;
        for (int i = 0; i < NIBBLES; i++) begin
            chk($sformatf("%s_busy%0d", tag, i), 32'({busy, res_valid, start_ready}), 32'b100);
            tick();
        end
        chk({tag, "_done"}, 32'({busy, res_valid, start_ready}), 32'b010);
        chk({tag, "_sum"}, 32'(sum), 32'(esum));
        chk({tag, "_cout"}, 32'(cout), 32'(ecout));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eovf));
        tick();
        chk({tag, "_handoff"}, 32'({busy, res_valid, start_ready}), 32'b001);
        chk({tag, "_hold_sum"}, 32'(sum), 32'(esum));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        start_valid = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        sub         = 1'b0;
        res_ready   = 1'b0;

        // ---- 1: reset ----
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ctrl", 32'({start_ready, busy, res_valid}), 32'b100);
        chk("rst_sum", 32'(sum), 32'h0000);
        chk("rst_flags", 32'({cout, overflow}), 32'b00);
        tick();
        chk("rst_idle_hold", 32'({start_ready, busy, res_valid}), 32'b100);

        // ---- 2..4: basic arithmetic ----
        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("add_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`ifdef NSA_SUB_EN
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
`else
        run_op("sub_ignored", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
`endif

        // ---- 5: backpressure with start_valid held high ----
        res_ready   = 1'b0;
        a           = 16'h0102;
        b           = 16'h0304;
        cin         = 1'b0;
        start_valid = 1'b1;
        tick();
        // Operands change while RUN; the latched ones must be used.
        a = 16'h1111;
        b = 16'h2222;
        for (int i = 0; i < NIBBLES; i++) begin
            tick();
        end
        chk("bp_done", 32'({busy, res_valid, start_ready}), 32'b010);
        chk("bp_sum", 32'(sum), 32'h0406);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_stall%0d_ctrl", i), 32'({busy, res_valid, start_ready}), 32'b010);
            chk($sformatf("bp_stall%0d_sum", i), 32'(sum), 32'h0406);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_handoff", 32'({busy, res_valid, start_ready}), 32'b001);
        chk("bp_handoff_sum", 32'(sum), 32'h0406);
        tick();
        chk("bp_accept_next", 32'({busy, res_valid, start_ready}), 32'b100);
        chk("bp_accept_clr", 32'(sum), 32'h0000);
        start_valid = 1'b0;
        for (int i = 0; i < NIBBLES; i++) begin
            tick();
        end
        chk("bp2_done", 32'({busy, res_valid, start_ready}), 32'b010);
        chk("bp2_sum", 32'(sum), 32'h3333);
        chk("bp2_flags", 32'({cout, overflow}), 32'b00);
        tick();
        chk("bp2_handoff", 32'({busy, res_valid, start_ready}), 32'b001);

        // ---- 6: reset in the middle of RUN ----
        a           = 16'hAAAA;
        b           = 16'h5555;
        cin         = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        chk("mid_run", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ctrl", 32'({start_ready, busy, res_valid}), 32'b100);
        chk("mid_rst_sum", 32'(sum), 32'h0000);
        chk("mid_rst_flags", 32'({cout, overflow}), 32'b00);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("mid_rst_novalid%0d", i), 32'(res_valid), 32'd0);
        end
        run_op("after_rst", 16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
